// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle add/subtract. WIDTH-bit operands are consumed
// CHUNK bits per clock through one CHUNK-bit adder slice. The carry is held in
// a register between chunks. Result bits are shifted into the vacated top of
// the A operand register, so no separate accumulator is needed.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_adder_seq: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb;      // opa also collects result bits from the top
    logic [WIDTH-1:0] opa_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last;
    logic [CHUNK:0]   csum;          // {chunk carry-out, chunk sum}
    logic             cmsb;          // carry into the chunk's top bit

    // One CHUNK-bit slice of the adder, fed from the low end of the operands
    assign csum = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    assign cmsb = csum[CHUNK-1] ^ opa[CHUNK-1] ^ opb[CHUNK-1];
    assign last = (count == LAST);
    assign busy = (state == RUN);

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign opa_nxt = csum[CHUNK-1:0];
        end else begin : g_multi
            assign opa_nxt = {csum[CHUNK-1:0], opa[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: start only matters in IDLE, RUN ends after the last chunk
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-chunk shift/add, and result registers updated only at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    opa   <= A;
                    opb   <= sub ? ~B : B;
                    carry <= sub ? 1'b1 : C;
                    count <= '0;
                end
            end else begin
                opa   <= opa_nxt;
                opb   <= opb >> CHUNK;
                carry <= csum[CHUNK];
                count <= count + CW'(1);
                if (last) begin
                    done <= 1'b1;
                    sum  <= opa_nxt;
                    cout <= csum[CHUNK];
                    ovf  <= csum[CHUNK] ^ cmsb;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed and random checks of serial_adder_seq in an
// 8-bit/1-bit-chunk and a 16-bit/4-bit-chunk configuration.
module tb_serial_adder_seq;

    logic        clk, rst_n;
    logic        start8, sub8, c8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, sub16, c16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    int          n_chk, n_err;

    serial_adder_seq #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8), .C(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    serial_adder_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .A(a16), .B(b16), .C(c16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word addition, overflow from operand/result signs
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic c,
                                  output logic [31:0] sm, output logic co, output logic ov);
        logic [63:0] mask, bx, t;
        mask = (64'd1 << w) - 64'd1;
        bx   = s ? (~{32'd0, b}) & mask : {32'd0, b};
        t    = {32'd0, a} + bx + (s ? 64'd1 : {63'd0, c});
        sm   = t[31:0] & mask[31:0];
        co   = t[w];
        ov   = (a[w-1] == bx[w-1]) && (sm[w-1] != a[w-1]);
    endfunction

    // Present a request for one cycle; returns at the negedge after the sampling edge
    task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
        sub8 = s; a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait for done; optionally re-pulse start with other operands at cycle inj
    task automatic wait8(input string tag, input int inj, input logic [7:0] es,
                         input logic eco, input logic eov);
        int cyc, bcnt;
        logic [7:0] prev;
        logic held;
        cyc = 0; bcnt = 0; prev = sum8; held = 1'b1;
        while (!done8 && cyc < 40) begin
            if (busy8) bcnt++;
            if (sum8 !== prev) held = 1'b0;
            if (cyc == inj) begin
                start8 = 1'b1; sub8 = 1'b1; a8 = 8'hAA; b8 = 8'hBB; c8 = 1'b1;
            end
            if (cyc == inj + 1) start8 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"},  32'(cyc), 32'd8);
        chk({tag, "_busy"}, 32'(bcnt), 32'd8);
        chk({tag, "_hold"}, 32'(held), 32'd1);
        chk({tag, "_sum"},  32'(sum8), 32'(es));
        chk({tag, "_cout"}, 32'(cout8), 32'(eco));
        chk({tag, "_ovf"},  32'(ovf8), 32'(eov));
    endtask

    task automatic op8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic eco, input logic eov);
        go8(s, a, b, c);
        wait8(tag, -1, es, eco, eov);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic op16(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic eco, input logic eov);
        int cyc;
        logic [15:0] prev;
        logic held;
        sub16 = s; a16 = a; b16 = b; c16 = c; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0; prev = sum16; held = 1'b1;
        while (!done16 && cyc < 40) begin
            if (sum16 !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"},  32'(cyc), 32'd4);
        chk({tag, "_hold"}, 32'(held), 32'd1);
        chk({tag, "_sum"},  32'(sum16), 32'(es));
        chk({tag, "_cout"}, 32'(cout16), 32'(eco));
        chk({tag, "_ovf"},  32'(ovf16), 32'(eov));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done16), 32'd0);
    endtask

    initial begin
        logic [31:0] esm;
        logic        eco, eov, rs, rc;
        logic [15:0] ra, rb;
        int          dn;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; c8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; c16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_ovf",  32'(ovf8),  32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed add / subtract vectors
        op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_03_04", 1'b0, 8'h03, 8'h04, 1'b1, 8'h08, 1'b0, 1'b0);

        // start while busy is ignored
        go8(1'b0, 8'h12, 8'h34, 1'b0);
        wait8("ignore", 3, 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        chk("ignore_pulse", 32'(done8), 32'd0);

        // back-to-back: start accepted on the done cycle
        go8(1'b0, 8'h55, 8'h0A, 1'b0);
        wait8("b2b1", -1, 8'h5F, 1'b0, 1'b0);
        go8(1'b0, 8'h10, 8'h20, 1'b1);
        chk("b2b_pulse", 32'(done8), 32'd0);
        chk("b2b_busy",  32'(busy8), 32'd1);
        wait8("b2b2", -1, 8'h31, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b2_pulse", 32'(done8), 32'd0);

        op8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Reset mid-operation: outputs clear at once, no done afterwards
        go8(1'b0, 8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",  32'(sum8),  32'd0);
        chk("mid_rst_cout", 32'(cout8), 32'd0);
        chk("mid_rst_ovf",  32'(ovf8),  32'd0);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) dn++;
        end
        chk("mid_rst_nodone", 32'(dn), 32'd0);
        op8("post_rst", 1'b1, 8'h20, 8'h21, 1'b0, 8'hFF, 1'b0, 1'b0);

        // 16-bit, 4-bit chunks
        op16("w16_ffff", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("w16_sub",  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom); rc = 1'($urandom);
            ra = 16'($urandom); rb = 16'($urandom);
            model(16, {16'd0, ra}, {16'd0, rb}, rs, rc, esm, eco, eov);
            op16("rnd16", rs, ra, rb, rc, esm[15:0], eco, eov);
        end
        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom); rc = 1'($urandom);
            ra = 16'($urandom); rb = 16'($urandom);
            model(8, {24'd0, ra[7:0]}, {24'd0, rb[7:0]}, rs, rc, esm, eco, eov);
            op8("rnd8", rs, ra[7:0], rb[7:0], rc, esm[7:0], eco, eov);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
